// File: rtl/stream_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_demux: registered valid/ready 1:N demux with optional packet lock  |
// | Option macro STREAM_DEMUX_DROP_EN: drop out-of-range beats, add drop_cnt  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module stream_demux #(
  parameter  int DWIDTH   = 16,
  parameter  int OUTPUTS  = 4,
  parameter  int PKT_MODE = 1,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = $clog2(OUTPUTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DWIDTH-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [SEL_W-1:0]          in_sel,
  output logic                      in_ready,
  output logic [DWIDTH*OUTPUTS-1:0] out_data,
  output logic [OUTPUTS-1:0]        out_valid,
  output logic [OUTPUTS-1:0]        out_last,
  input  logic [OUTPUTS-1:0]        out_ready
`ifdef STREAM_DEMUX_DROP_EN
  ,
  output logic [CNT_W-1:0]          drop_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SEL_W:0]   NUM_CH  = (SEL_W+1)'(OUTPUTS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(OUTPUTS-1);

  if (OUTPUTS < 2 || CNT_W < 1) begin : g_bad_params
    $error("stream_demux: OUTPUTS must be >= 2 and CNT_W >= 1");
  end

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          lock_sel_q, lock_sel_d;
  logic [OUTPUTS-1:0]        out_valid_q, out_valid_d;
  logic [OUTPUTS-1:0]        out_last_q, out_last_d;
  logic [DWIDTH*OUTPUTS-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]          sel_raw, tgt;
  logic                      sel_oor, drop, accept;

  always_comb begin
    // Locked packets keep the raw first-beat select so an out-of-range packet is handled as a whole
    sel_raw = (state_q == LOCKED) ? lock_sel_q : in_sel;
    sel_oor = ({1'b0, sel_raw} >= NUM_CH);
`ifdef STREAM_DEMUX_DROP_EN
    drop = sel_oor;
    tgt  = sel_raw;
`else
    drop = 1'b0;
    tgt  = sel_oor ? LAST_CH : sel_raw;
`endif

    in_ready = drop;
    for (int i = 0; i < OUTPUTS; i++) begin
      if (!drop && tgt == SEL_W'(i)) in_ready = !out_valid_q[i] || out_ready[i];
    end
    accept = in_valid && in_ready;

    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    for (int i = 0; i < OUTPUTS; i++) begin
      if (out_valid_q[i] && out_ready[i]) out_valid_d[i] = 1'b0;
      if (accept && !drop && tgt == SEL_W'(i)) begin
        out_valid_d[i]                   = 1'b1;
        out_last_d[i]                    = in_last;
        out_data_d[i*DWIDTH +: DWIDTH]   = in_data;
      end
    end

    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (PKT_MODE != 0 && accept) begin
      if (state_q == IDLE) begin
        if (!in_last) begin
          state_d    = LOCKED;
          lock_sel_d = in_sel;
        end
      end else if (in_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_sel_q  <= '0;
      out_valid_q <= '0;
      out_last_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_sel_q  <= lock_sel_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

`ifdef STREAM_DEMUX_DROP_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && drop && drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stream_demux: two demux instances (4ch streaming, 3ch packet) vs model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_stream_demux;
  localparam int DW = 16;
  localparam int CW = 16;
`ifdef STREAM_DEMUX_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_last;
  logic [1:0]    in_valid;
  logic          a_in_ready, b_in_ready;
  logic [4*DW-1:0] a_out_data;
  logic [3:0]      a_out_valid, a_out_last, a_out_ready;
  logic [3*DW-1:0] b_out_data;
  logic [2:0]      b_out_valid, b_out_last, b_out_ready;
  logic [3:0]      rdy [2];
`ifdef STREAM_DEMUX_DROP_EN
  logic [CW-1:0]   a_drop, b_drop;
`endif

  assign a_out_ready = rdy[0];
  assign b_out_ready = rdy[1][2:0];

  stream_demux #(.DWIDTH(DW), .OUTPUTS(4), .PKT_MODE(0), .CNT_W(CW)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[0]), .in_last(in_last),
    .in_sel(in_sel), .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_last(a_out_last), .out_ready(a_out_ready)
`ifdef STREAM_DEMUX_DROP_EN
    , .drop_cnt(a_drop)
`endif
  );

  stream_demux #(.DWIDTH(DW), .OUTPUTS(3), .PKT_MODE(1), .CNT_W(CW)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[1]), .in_last(in_last),
    .in_sel(in_sel), .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_ready(b_out_ready)
`ifdef STREAM_DEMUX_DROP_EN
    , .drop_cnt(b_drop)
`endif
  );

  // Reference model: what each channel register should hold, per instance
  bit            m_valid [2][4];
  logic [DW-1:0] m_data  [2][4];
  bit            m_last  [2][4];
  bit            m_locked[2];
  int            m_lock  [2];
  int            m_drop  [2];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic int nout(int d);  return (d == 0) ? 4 : 3; endfunction
  function automatic bit pkt(int d);   return d == 1;           endfunction

  function automatic int tgt_of(int d);
    return m_locked[d] ? m_lock[d] : int'(in_sel);
  endfunction

  function automatic bit dropped(int d, int t);
    return DROP_EN && (t >= nout(d));
  endfunction

  function automatic int route(int d, int t);
    return (t >= nout(d)) ? nout(d) - 1 : t;
  endfunction

  function automatic bit exp_ready(int d);
    int t = tgt_of(d);
    if (dropped(d, t)) return 1'b1;
    return !m_valid[d][route(d, t)] || rdy[d][route(d, t)];
  endfunction

  function automatic logic obs_ready(int d);
    return (d == 0) ? a_in_ready : b_in_ready;
  endfunction
  function automatic logic obs_valid(int d, int c);
    return (d == 0) ? a_out_valid[c] : b_out_valid[c];
  endfunction
  function automatic logic obs_last(int d, int c);
    return (d == 0) ? a_out_last[c] : b_out_last[c];
  endfunction
  function automatic logic [DW-1:0] obs_data(int d, int c);
    return (d == 0) ? a_out_data[c*DW +: DW] : b_out_data[c*DW +: DW];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        m_valid[d][c] = 1'b0; m_data[d][c] = '0; m_last[d][c] = 1'b0;
      end
      m_locked[d] = 1'b0; m_lock[d] = 0; m_drop[d] = 0;
    end
  endtask

  task automatic model_step(int d, bit acc);
    int t = tgt_of(d);
    for (int c = 0; c < 4; c++) if (m_valid[d][c] && rdy[d][c]) m_valid[d][c] = 1'b0;
    if (acc) begin
      if (dropped(d, t)) begin
        if (m_drop[d] < (1 << CW) - 1) m_drop[d]++;
      end else begin
        m_valid[d][route(d, t)] = 1'b1;
        m_data[d][route(d, t)]  = in_data;
        m_last[d][route(d, t)]  = in_last;
      end
      if (pkt(d)) begin
        if (m_locked[d]) begin
          if (in_last) m_locked[d] = 1'b0;
        end else if (!in_last) begin
          m_locked[d] = 1'b1;
          m_lock[d]   = int'(in_sel);
        end
      end
    end
  endtask

  task automatic check_outputs(int d);
    for (int c = 0; c < nout(d); c++) begin
      chk($sformatf("valid d%0d ch%0d", d, c), obs_valid(d, c), m_valid[d][c]);
      chk($sformatf("last d%0d ch%0d", d, c),  obs_last(d, c),  m_last[d][c]);
      chk($sformatf("data d%0d ch%0d", d, c),  obs_data(d, c),  m_data[d][c]);
    end
`ifdef STREAM_DEMUX_DROP_EN
    chk($sformatf("drop_cnt d%0d", d), (d == 0) ? a_drop : b_drop, m_drop[d]);
`endif
  endtask

  // One clock: check in_ready before the edge, advance model, check registers after
  task automatic tick(output bit acc_cur, input int cur);
    bit acc [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("in_ready d%0d", d), obs_ready(d), exp_ready(d));
      acc[d] = in_valid[d] && exp_ready(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d, acc[d]);
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d);
    acc_cur = acc[cur];
  endtask

  task automatic send(int d, int sel, logic [DW-1:0] data, bit last);
    bit acc = 1'b0;
    int n   = 0;
    in_valid[d] = 1'b1; in_sel = 2'(sel); in_data = data; in_last = last;
    do begin
      tick(acc, d);
      n++;
    end while (!acc && n < 40);
    in_valid[d] = 1'b0;
    chk("send_accepted", acc, 1'b1);
  endtask

  initial begin
    bit acc;
    bit pend;
    rst_n = 1'b0; in_valid = '0; in_sel = '0; in_data = '0; in_last = 1'b0;
    rdy[0] = '0; rdy[1] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d);
    rst_n = 1'b1;

    // Streaming instance: four back-to-back beats, one per channel
    rdy[0] = 4'hF;
    for (int s = 0; s < 4; s++) send(0, s, DW'(16'hA0 + s), 1'b0);

    // Packet instance: 3-beat packet locked to ch2, then a single-beat packet to ch0
    rdy[1] = 4'h7;
    send(1, 2, 16'h1001, 1'b0);
    send(1, 0, 16'h1002, 1'b0);
    send(1, 1, 16'h1003, 1'b1);
    send(1, 0, 16'h1004, 1'b1);

    // Head-of-line stall on ch1, release lets the waiting beat in the same cycle
    rdy[0] = 4'b1101;
    send(0, 1, 16'h0111, 1'b0);
    in_valid[0] = 1'b1; in_sel = 2'd1; in_data = 16'h0222; in_last = 1'b1;
    tick(acc, 0); chk("hol_stall_1", acc, 1'b0);
    tick(acc, 0); chk("hol_stall_2", acc, 1'b0);
    rdy[0] = 4'hF;
    tick(acc, 0); chk("hol_release", acc, 1'b1);
    in_valid[0] = 1'b0;

    // Stalled ch0 does not block a beat for ch3
    rdy[0] = 4'b1110;
    send(0, 0, 16'h00AA, 1'b0);
    send(0, 3, 16'h00BB, 1'b0);
    rdy[0] = 4'hF;
    tick(acc, 0);

    // Out-of-range select on a 2-beat packet (dropped or clamped to ch2)
    send(1, 3, 16'h3001, 1'b0);
    send(1, 0, 16'h3002, 1'b1);
    tick(acc, 1);

    // Reset while locked with two channels holding beats
    rdy[1] = 4'h0;
    send(1, 0, 16'h5001, 1'b1);
    send(1, 2, 16'h5002, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) check_outputs(d);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy[1] = 4'h7;
    send(1, 1, 16'h6001, 1'b0);
    send(1, 0, 16'h6002, 1'b1);
    tick(acc, 1);

    // Randomized traffic with random sink back-pressure on each instance
    for (int d = 0; d < 2; d++) begin
      pend = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (!pend) begin
          in_valid[d] = ($urandom_range(0, 3) != 0);
          in_sel      = 2'($urandom_range(0, 3));
          in_data     = DW'($urandom);
          in_last     = ($urandom_range(0, 2) == 0);
        end
        for (int c = 0; c < 4; c++) rdy[d][c] = ($urandom_range(0, 9) < 7);
        tick(acc, d);
        pend = in_valid[d] && !acc;
      end
      in_valid[d] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
